// File: rtl/aes_enc_iter_core_if.sv
// aes_enc_iter_core_if: key, plaintext and ciphertext handshake bundle for aes_enc_iter_core.
// The iv signal exists only when AES_CBC_EN is defined.
interface aes_enc_iter_core_if #(
   parameter int KEY_BITS = 128
) ();
   logic [KEY_BITS-1:0] key_in;
   logic                key_load;
   logic                key_ready;
   logic                in_valid;
   logic                in_ready;
   logic [127:0]        plain_text;
   logic                out_valid;
   logic                out_ready;
   logic [127:0]        cipher;
`ifdef AES_CBC_EN
   logic [127:0]        iv;
   modport master (output key_in, key_load, in_valid, plain_text, out_ready, iv,
                   input key_ready, in_ready, out_valid, cipher);
   modport slave (input key_in, key_load, in_valid, plain_text, out_ready, iv,
                  output key_ready, in_ready, out_valid, cipher);
`else
   modport master (output key_in, key_load, in_valid, plain_text, out_ready,
                   input key_ready, in_ready, out_valid, cipher);
   modport slave (input key_in, key_load, in_valid, plain_text, out_ready,
                  output key_ready, in_ready, out_valid, cipher);
`endif
endinterface

// File: rtl/aes_enc_iter_core.sv
// aes_enc_iter_core: iterative AES-128/192/256 encryptor, one key word then one round per clock.
// Define AES_CBC_EN to chain blocks in CBC mode with an iv sampled on key_load.
module aes_enc_iter_core #(
   parameter int KEY_BITS = 128
) (
   input logic                clk,
   input logic                rst,
   aes_enc_iter_core_if.slave bus
);
   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);
   localparam logic [5:0] NK6 = 6'(NK);
   localparam logic [5:0] LAST_W = 6'(NW - 1);
   localparam logic [2:0] NK_LAST = 3'(NK - 1);
   localparam logic [3:0] LAST_R = 4'(NR);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   typedef enum logic [2:0] {NOKEY, KEXP, READY, ROUND, DONE} state_t;

   // Entry x sits at bits 8*(255-x)+7 downto 8*(255-x).
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b111} -: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // SubBytes fused with ShiftRows; byte 4c+r is row r of column c.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      return o;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
   endfunction

   state_t       r_fsm, w_fsm_nxt;
   logic [31:0]  r_w [NW];
   logic [5:0]   r_i;
   logic [2:0]   r_kpos;
   logic [7:0]   r_rcon;
   logic [3:0]   r_round;
   logic [127:0] r_state, r_cipher;
   logic         w_last_round;
   logic [31:0]  w_prev, w_back, w_temp;
   logic [127:0] w_block, w_rk0, w_rk, w_sr, w_round;
`ifdef AES_CBC_EN
   logic [127:0] r_chain;
   assign w_block = bus.plain_text ^ r_chain;
`else
   assign w_block = bus.plain_text;
`endif

   assign w_prev = r_w[r_i - 6'd1];
   assign w_back = r_w[r_i - NK6];
   // r_kpos tracks i mod Nk so no divider is needed for 192-bit keys.
   assign w_temp = (r_kpos == 3'd0) ? sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0}
                 : (NK == 8 && r_kpos == 3'd4) ? sub_word(w_prev) : w_prev;
   assign w_rk0 = {r_w[0], r_w[1], r_w[2], r_w[3]};
   assign w_rk = {r_w[{r_round, 2'b00}], r_w[{r_round, 2'b01}], r_w[{r_round, 2'b10}], r_w[{r_round, 2'b11}]};
   assign w_sr = sub_shift(r_state);
   assign w_last_round = r_round == LAST_R;
   assign w_round = (w_last_round ? w_sr : mix_columns(w_sr)) ^ w_rk;

   assign bus.key_ready = r_fsm inside {READY, ROUND, DONE};
   assign bus.in_ready = r_fsm == READY;
   assign bus.out_valid = r_fsm == DONE;
   assign bus.cipher = r_cipher;

   always_ff @(posedge clk or posedge rst)
      if (rst) r_fsm <= NOKEY;
      else r_fsm <= w_fsm_nxt;

   always_comb begin
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         KEXP:    if (r_i == LAST_W) w_fsm_nxt = READY;
         READY:   if (bus.in_valid) w_fsm_nxt = ROUND;
         ROUND:   if (w_last_round) w_fsm_nxt = DONE;
         DONE:    if (bus.out_ready) w_fsm_nxt = READY;
         default: w_fsm_nxt = r_fsm;
      endcase
      if (bus.key_load) w_fsm_nxt = KEXP;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int j = 0; j < NW; j++) r_w[j] <= '0;
         r_i <= '0;
         r_kpos <= '0;
         r_rcon <= '0;
         r_round <= '0;
         r_state <= '0;
         r_cipher <= '0;
`ifdef AES_CBC_EN
         r_chain <= '0;
`endif
      end else if (bus.key_load) begin
         for (int j = 0; j < NK; j++) r_w[j] <= bus.key_in[KEY_BITS-1-32*j -: 32];
         r_i <= NK6;
         r_kpos <= '0;
         r_rcon <= 8'h01;
`ifdef AES_CBC_EN
         r_chain <= bus.iv;
`endif
      end else begin
         if (r_fsm == KEXP) begin
            r_w[r_i] <= w_back ^ w_temp;
            r_i <= r_i + 6'd1;
            r_kpos <= (r_kpos == NK_LAST) ? 3'd0 : r_kpos + 3'd1;
            if (r_kpos == 3'd0) r_rcon <= xt(r_rcon);
         end
         if (r_fsm == READY && bus.in_valid) begin
            r_state <= w_block ^ w_rk0;
            r_round <= 4'd1;
         end
         if (r_fsm == ROUND) begin
            r_state <= w_round;
            r_round <= r_round + 4'd1;
            if (w_last_round) begin
               r_cipher <= w_round;
`ifdef AES_CBC_EN
               r_chain <= w_round;
`endif
            end
         end
      end
endmodule
